// File: rtl/cosim_cmp_pkg.sv
// Shared state type and arithmetic helpers for the co-simulation compare monitor.
package cosim_cmp_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, ARMED, DONE} state_e;

    localparam int unsigned MaxCntW = 32;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Increment that sticks at 2^w-1; callers truncate the result to w bits.
    function automatic logic [MaxCntW-1:0] sat_inc(input logic [MaxCntW-1:0] v,
                                                   input int unsigned w);
        logic [MaxCntW-1:0] lim;
        lim = (w >= MaxCntW) ? '1 : ((MaxCntW'(1) << w) - MaxCntW'(1));
        return (v >= lim) ? lim : v + MaxCntW'(1);
    endfunction

endpackage

// File: rtl/cosim_compare_monitor_if.sv
// Bundle of control, compared data and result signals between a bench and the monitor.
interface cosim_compare_monitor_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned STAMP_W = 32
);
    import cosim_cmp_pkg::*;

    localparam int unsigned ChW = idx_w(NUM_CH);

    logic                     start;
    logic                     stop;
    logic                     cmp_strobe;
    logic [NUM_CH-1:0]        ch_mask;
    logic [NUM_CH*DATA_W-1:0] golden_i;
    logic [NUM_CH*DATA_W-1:0] netlist_i;
    logic                     busy;
    logic                     done;
    logic                     pass;
    logic [CNT_W-1:0]         cmp_cnt;
    logic [CNT_W-1:0]         mismatch_cnt;
    logic                     cnt_sat;
    logic [NUM_CH-1:0]        mismatch_ch;
    logic [ChW-1:0]           first_ch;
    logic [STAMP_W-1:0]       first_stamp;
    logic [DATA_W-1:0]        first_golden;
    logic [DATA_W-1:0]        first_netlist;
    logic                     first_valid;

    modport master (
        output start, stop, cmp_strobe, ch_mask, golden_i, netlist_i,
        input  busy, done, pass, cmp_cnt, mismatch_cnt, cnt_sat, mismatch_ch,
        input  first_ch, first_stamp, first_golden, first_netlist, first_valid
    );

    modport slave (
        input  start, stop, cmp_strobe, ch_mask, golden_i, netlist_i,
        output busy, done, pass, cmp_cnt, mismatch_cnt, cnt_sat, mismatch_ch,
        output first_ch, first_stamp, first_golden, first_netlist, first_valid
    );

endinterface

// File: rtl/cosim_ch_compare.sv
// One channel of the monitor: masked 4-state compare plus a sticky mismatch flag.
module cosim_ch_compare #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic              mask,
    input  logic [DATA_W-1:0] golden,
    input  logic [DATA_W-1:0] netlist,
    output logic              mismatch,
    output logic              sticky
);

    // Case inequality so X/Z differences on the netlist side are caught.
    assign mismatch = mask && (golden !== netlist);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sticky <= 1'b0;
        end else if (en && mismatch) begin
            sticky <= 1'b1;
        end
    end

endmodule

// File: rtl/cosim_compare_monitor.sv
// Multi-channel golden-vs-netlist compare monitor with counters, first-mismatch capture
// and a registered pass/fail verdict.
module cosim_compare_monitor
    import cosim_cmp_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned STAMP_W    = 32,
    parameter int unsigned SETTLE_CMP = 1
) (
    input logic                    clk,
    input logic                    rst,
    cosim_compare_monitor_if.slave bus
);

    localparam int unsigned ChW  = idx_w(NUM_CH);
    localparam int unsigned SetW = idx_w(SETTLE_CMP + 1);

    state_e             state_q;
    logic [STAMP_W-1:0] stamp_q;
    logic [SetW-1:0]    settle_q;
    logic [CNT_W-1:0]   cmp_cnt_q, cmp_cnt_d;
    logic [CNT_W-1:0]   mm_cnt_q, mm_cnt_d;
    logic               sat_q, sat_d;
    logic               pass_q, pass_d;
    logic               fv_q;
    logic [ChW-1:0]     fch_q;
    logic [STAMP_W-1:0] fstamp_q;
    logic [DATA_W-1:0]  fgolden_q, fnetlist_q;

    logic [NUM_CH-1:0]  ch_mm, sticky;
    logic               any_mm, cmp_en, clear;
    logic [ChW-1:0]     hit_ch;
    logic [DATA_W-1:0]  hit_golden, hit_netlist;

    assign cmp_en = (state_q == ARMED) && bus.cmp_strobe;
    assign clear  = bus.start && ((state_q == IDLE) || (state_q == DONE));

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        cosim_ch_compare #(
            .DATA_W(DATA_W)
        ) u_cmp (
            .clk     (clk),
            .rst     (rst),
            .clear   (clear),
            .en      (cmp_en),
            .mask    (bus.ch_mask[k]),
            .golden  (bus.golden_i[k*DATA_W +: DATA_W]),
            .netlist (bus.netlist_i[k*DATA_W +: DATA_W]),
            .mismatch(ch_mm[k]),
            .sticky  (sticky[k])
        );
    end

    always_comb begin
        any_mm      = |ch_mm;
        hit_ch      = '0;
        hit_golden  = '0;
        hit_netlist = '0;
        // Walk downwards so the lowest mismatching channel wins.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ch_mm[k]) begin
                hit_ch      = ChW'(k);
                hit_golden  = bus.golden_i[k*DATA_W +: DATA_W];
                hit_netlist = bus.netlist_i[k*DATA_W +: DATA_W];
            end
        end
        cmp_cnt_d = cmp_cnt_q;
        mm_cnt_d  = mm_cnt_q;
        if (cmp_en) begin
            cmp_cnt_d = CNT_W'(sat_inc(MaxCntW'(cmp_cnt_q), CNT_W));
            if (any_mm) begin
                mm_cnt_d = CNT_W'(sat_inc(MaxCntW'(mm_cnt_q), CNT_W));
            end
        end
        sat_d  = sat_q | (&cmp_cnt_d) | (&mm_cnt_d);
        pass_d = (mm_cnt_d == '0) && (cmp_cnt_d != '0) && !sat_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            stamp_q    <= '0;
            settle_q   <= '0;
            cmp_cnt_q  <= '0;
            mm_cnt_q   <= '0;
            sat_q      <= 1'b0;
            pass_q     <= 1'b0;
            fv_q       <= 1'b0;
            fch_q      <= '0;
            fstamp_q   <= '0;
            fgolden_q  <= '0;
            fnetlist_q <= '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q    <= (SETTLE_CMP == 0) ? ARMED : SETTLE;
                        stamp_q    <= '0;
                        settle_q   <= '0;
                        cmp_cnt_q  <= '0;
                        mm_cnt_q   <= '0;
                        sat_q      <= 1'b0;
                        pass_q     <= 1'b0;
                        fv_q       <= 1'b0;
                        fch_q      <= '0;
                        fstamp_q   <= '0;
                        fgolden_q  <= '0;
                        fnetlist_q <= '0;
                    end
                end
                SETTLE, ARMED: begin
                    stamp_q   <= stamp_q + STAMP_W'(1);
                    cmp_cnt_q <= cmp_cnt_d;
                    mm_cnt_q  <= mm_cnt_d;
                    sat_q     <= sat_d;
                    if (cmp_en && any_mm && !fv_q) begin
                        fv_q       <= 1'b1;
                        fch_q      <= hit_ch;
                        fstamp_q   <= stamp_q;
                        fgolden_q  <= hit_golden;
                        fnetlist_q <= hit_netlist;
                    end
                    if (bus.stop) begin
                        state_q <= DONE;
                        pass_q  <= pass_d;
                    end else if ((state_q == SETTLE) && bus.cmp_strobe) begin
                        if (settle_q == SetW'(SETTLE_CMP - 1)) begin
                            state_q <= ARMED;
                        end else begin
                            settle_q <= settle_q + SetW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy          = (state_q == SETTLE) || (state_q == ARMED);
    assign bus.done          = (state_q == DONE);
    assign bus.pass          = pass_q;
    assign bus.cmp_cnt       = cmp_cnt_q;
    assign bus.mismatch_cnt  = mm_cnt_q;
    assign bus.cnt_sat       = sat_q;
    assign bus.mismatch_ch   = sticky;
    assign bus.first_ch      = fch_q;
    assign bus.first_stamp   = fstamp_q;
    assign bus.first_golden  = fgolden_q;
    assign bus.first_netlist = fnetlist_q;
    assign bus.first_valid   = fv_q;

endmodule

// File: tb/tb_cosim_compare_monitor.sv
// Bench for cosim_compare_monitor: a 16-bit-counter and a 4-bit-counter instance share stimulus.
`timescale 1ns/1ps
module tb_cosim_compare_monitor;

    localparam int unsigned DW  = 32;
    localparam int unsigned NCH = 4;
    localparam int unsigned BW  = DW * NCH;

    typedef enum int {MIdle, MSettle, MArmed, MDone} mstate_e;
    typedef struct {
        logic [NCH-1:0] mask;
        logic [BW-1:0]  g;
        logic [BW-1:0]  n;
        logic [NCH-1:0] exp_mm;
    } vec_t;
    typedef struct {
        logic [NCH-1:0] mm;
        logic [31:0]    stamp;
        logic [1:0]     ch;
        logic [DW-1:0]  g;
        logic [DW-1:0]  n;
    } sb_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_v, stop_v, strobe_v;
    logic [NCH-1:0] mask_v;
    logic [BW-1:0]  g_v, n_v;
    logic [NCH-1:0] exp_mm;

    cosim_compare_monitor_if #(.DATA_W(DW), .NUM_CH(NCH), .CNT_W(16), .STAMP_W(32)) bus_a ();
    cosim_compare_monitor_if #(.DATA_W(DW), .NUM_CH(NCH), .CNT_W(4), .STAMP_W(32)) bus_b ();

    assign bus_a.start      = start_v;
    assign bus_a.stop       = stop_v;
    assign bus_a.cmp_strobe = strobe_v;
    assign bus_a.ch_mask    = mask_v;
    assign bus_a.golden_i   = g_v;
    assign bus_a.netlist_i  = n_v;
    assign bus_b.start      = start_v;
    assign bus_b.stop       = stop_v;
    assign bus_b.cmp_strobe = strobe_v;
    assign bus_b.ch_mask    = mask_v;
    assign bus_b.golden_i   = g_v;
    assign bus_b.netlist_i  = n_v;

    cosim_compare_monitor #(
        .DATA_W(DW), .NUM_CH(NCH), .CNT_W(16), .STAMP_W(32), .SETTLE_CMP(1)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a)
    );

    cosim_compare_monitor #(
        .DATA_W(DW), .NUM_CH(NCH), .CNT_W(4), .STAMP_W(32), .SETTLE_CMP(1)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    mstate_e     m_state;
    int unsigned m_stamp, m_cmp_a, m_mm_a, m_cmp_b, m_mm_b;
    bit          m_sat_a, m_sat_b, m_fv;
    logic [NCH-1:0] m_sticky;
    sb_t         m_first;
    sb_t         sbq[$];
    vec_t        vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NCH-1:0] model_mm(input logic [NCH-1:0] m, input logic [BW-1:0] g,
                                                input logic [BW-1:0] n);
        logic [NCH-1:0] r;
        for (int k = 0; k < NCH; k++) r[k] = m[k] && (g[k*DW +: DW] !== n[k*DW +: DW]);
        return r;
    endfunction

    function automatic int unsigned msat(input int unsigned v, input int unsigned max);
        return (v >= max) ? max : v + 1;
    endfunction

    task automatic model_clear();
        m_stamp = 0; m_cmp_a = 0; m_mm_a = 0; m_cmp_b = 0; m_mm_b = 0;
        m_sat_a = 0; m_sat_b = 0; m_fv = 0; m_sticky = '0;
        m_first = '{default: '0};
    endtask

    task automatic cycle();
        sb_t e;
        bit  popped;
        popped = 0;
        if (m_state == MArmed && strobe_v === 1'b1 && rst !== 1'b1) begin
            e.mm    = exp_mm;
            e.stamp = m_stamp;
            e.ch    = '0;
            for (int k = NCH - 1; k >= 0; k--) if (exp_mm[k]) e.ch = 2'(k);
            e.g = g_v[e.ch*DW +: DW];
            e.n = n_v[e.ch*DW +: DW];
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            model_clear();
            m_state = MIdle;
            sbq.delete();
        end else begin
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                popped = 1;
                m_cmp_a = msat(m_cmp_a, 65535);
                m_cmp_b = msat(m_cmp_b, 15);
                if (|e.mm) begin
                    m_mm_a = msat(m_mm_a, 65535);
                    m_mm_b = msat(m_mm_b, 15);
                    if (!m_fv) begin
                        m_fv = 1;
                        m_first = e;
                    end
                end
                m_sticky |= e.mm;
                m_sat_a |= (m_cmp_a == 65535) || (m_mm_a == 65535);
                m_sat_b |= (m_cmp_b == 15) || (m_mm_b == 15);
            end
            case (m_state)
                MIdle, MDone: if (start_v) begin model_clear(); m_state = MSettle; end
                MSettle: begin
                    m_stamp++;
                    if (stop_v) m_state = MDone;
                    else if (strobe_v) m_state = MArmed;
                end
                default: begin
                    m_stamp++;
                    if (stop_v) m_state = MDone;
                end
            endcase
        end
        chk("busy", bus_a.busy, (m_state == MSettle) || (m_state == MArmed));
        chk("done", bus_a.done, m_state == MDone);
        if (popped) begin
            chk("cmp_cnt", bus_a.cmp_cnt, m_cmp_a);
            chk("mismatch_cnt", bus_a.mismatch_cnt, m_mm_a);
            chk("mismatch_ch", bus_a.mismatch_ch, m_sticky);
            chk("mismatch_cnt_w4", bus_b.mismatch_cnt, m_mm_b);
            chk("cnt_sat_w4", bus_b.cnt_sat, m_sat_b);
        end
    endtask

    task automatic drive(input bit st, input bit sp, input bit sb, input logic [NCH-1:0] m,
                         input logic [BW-1:0] g, input logic [BW-1:0] n,
                         input logic [NCH-1:0] em);
        start_v = st; stop_v = sp; strobe_v = sb; mask_v = m; g_v = g; n_v = n; exp_mm = em;
        cycle();
    endtask

    task automatic step(input bit st, input bit sp, input bit sb, input logic [NCH-1:0] m,
                        input logic [BW-1:0] g, input logic [BW-1:0] n);
        drive(st, sp, sb, m, g, n, model_mm(m, g, n));
    endtask

    task automatic check_verdict();
        chk("pass", bus_a.pass, (m_mm_a == 0) && (m_cmp_a != 0) && !m_sat_a);
        chk("pass_w4", bus_b.pass, (m_mm_b == 0) && (m_cmp_b != 0) && !m_sat_b);
        chk("cmp_cnt_w4", bus_b.cmp_cnt, m_cmp_b);
        chk("cnt_sat", bus_a.cnt_sat, m_sat_a);
        chk("first_valid", bus_a.first_valid, m_fv);
        chk("first_ch", bus_a.first_ch, m_first.ch);
        chk("first_stamp", bus_a.first_stamp, m_first.stamp);
        chk("first_golden", bus_a.first_golden, m_first.g);
        chk("first_netlist", bus_a.first_netlist, m_first.n);
    endtask

    task automatic chk_zero();
        chk("zero flags", {bus_a.busy, bus_a.done, bus_a.pass, bus_a.cnt_sat, bus_a.first_valid,
                           bus_b.busy, bus_b.done, bus_b.pass, bus_b.cnt_sat}, '0);
        chk("zero counts", {bus_a.cmp_cnt, bus_a.mismatch_cnt, bus_b.cmp_cnt,
                            bus_b.mismatch_cnt}, '0);
        chk("zero mismatch_ch", {bus_a.mismatch_ch, bus_b.mismatch_ch}, '0);
        chk("zero first_ch/stamp", {bus_a.first_ch, bus_a.first_stamp}, '0);
        chk("zero first data", {bus_a.first_golden, bus_a.first_netlist}, '0);
    endtask

    initial begin
        logic [BW-1:0] same, xn, one;
        start_v = 0; stop_v = 0; strobe_v = 0; mask_v = '1; g_v = '0; n_v = '0; exp_mm = '0;
        rst = 1;
        model_clear();
        m_state = MIdle;
        same = {4{32'h1234_5678}};
        one  = {96'h0, 32'h1};
        xn   = '0;
        xn[96] = 1'bx;

        vecs[0] = '{4'hF, {BW{1'b0}}, {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0}, 4'b0100};
        vecs[1] = '{4'hF, {4{32'hAAAA_5555}},
                    {32'hAAAA_5555, 32'hAAAA_5555, 32'hAAAA_5554, 32'hAAAA_5555}, 4'b0010};
        vecs[2] = '{4'hF, {4{32'hCAFE_F00D}}, {4{32'hCAFE_F00D}}, 4'b0000};
        vecs[3] = '{4'hF, {BW{1'b0}}, xn, {(xn[127:96] !== 32'h0), 3'b000}};
        vecs[4] = '{4'b0111, {BW{1'b0}}, xn, 4'b0000};
        vecs[5] = '{4'b0000, {BW{1'b0}}, {BW{1'b1}}, 4'b0000};
        vecs[6] = '{4'hF, {BW{1'b0}}, {32'h8000_0000, 32'h0, 32'h0, 32'h1}, 4'b1001};

        cycle();
        cycle();
        chk_zero();
        rst = 0;

        // Clean run: first strobe is discarded by the settle window.
        step(1, 0, 0, 4'hF, same, same);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 4'hF, same, same);
        step(0, 1, 0, 4'hF, same, same);
        check_verdict();
        chk("t1 pass", bus_a.pass, 1);
        chk("t1 cmp_cnt", bus_a.cmp_cnt, 9);
        chk("t1 mismatch_cnt", bus_a.mismatch_cnt, 0);

        // Table run with first mismatch landing at stamp 7.
        step(1, 0, 0, 4'hF, '0, '0);
        step(0, 0, 1, 4'hF, '0, '0);
        for (int i = 0; i < 16 && m_stamp != 7; i++) step(0, 0, 0, 4'hF, '0, '0);
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 1, vecs[i].mask, vecs[i].g, vecs[i].n, vecs[i].exp_mm);
            if (i == 1) begin
                chk("t2 first_ch", bus_a.first_ch, 2);
                chk("t2 first_stamp", bus_a.first_stamp, 7);
                chk("t2 first_golden", bus_a.first_golden, 0);
                chk("t2 first_netlist", bus_a.first_netlist, 32'hDEAD_BEEF);
                chk("t2 mismatch_ch", bus_a.mismatch_ch, 4'b0110);
                chk("t2 mismatch_cnt", bus_a.mismatch_cnt, 2);
            end
        end
        step(0, 1, 0, 4'hF, '0, '0);
        check_verdict();
        chk("t2 pass", bus_a.pass, 0);

        // Saturation on the 4-bit instance.
        step(1, 0, 0, 4'h1, '0, one);
        step(0, 0, 1, 4'h1, '0, one);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 4'h1, '0, one);
        step(0, 1, 0, 4'h1, '0, one);
        check_verdict();
        chk("t3 w4 mismatch_cnt", bus_b.mismatch_cnt, 15);
        chk("t3 w4 cnt_sat", bus_b.cnt_sat, 1);
        chk("t3 w4 pass", bus_b.pass, 0);
        chk("t3 mismatch_cnt", bus_a.mismatch_cnt, 20);

        // Empty run, then strobe coinciding with stop.
        step(1, 0, 0, 4'hF, '0, '0);
        step(0, 1, 0, 4'hF, '0, '0);
        check_verdict();
        chk("t4 empty pass", bus_a.pass, 0);
        chk("t4 empty cmp_cnt", bus_a.cmp_cnt, 0);
        step(1, 0, 0, 4'hF, '0, '0);
        step(0, 0, 1, 4'hF, '0, '0);
        step(0, 1, 1, 4'hF, '0, {32'h5, 96'h0});
        check_verdict();
        chk("t4 stop+strobe mismatch_cnt", bus_a.mismatch_cnt, 1);
        chk("t4 stop+strobe cmp_cnt", bus_a.cmp_cnt, 1);

        // Reset mid-run, then start+stop together from IDLE.
        step(1, 0, 0, 4'hF, '0, one);
        step(0, 0, 1, 4'hF, '0, one);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 4'hF, '0, one);
        rst = 1;
        step(0, 0, 0, 4'hF, '0, one);
        chk_zero();
        rst = 0;
        step(1, 1, 0, 4'hF, same, same);
        chk("t5 start wins", bus_a.busy, 1);
        step(0, 0, 1, 4'hF, same, same);
        step(0, 0, 1, 4'hF, same, same);
        step(0, 0, 1, 4'hF, same, same);
        step(0, 1, 0, 4'hF, same, same);
        check_verdict();
        chk("t5 pass", bus_a.pass, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
